// File: rtl/pipeline_stall_controller_pkg.sv
// Shared pipeline definitions: controller state encodings and mult/div latency default.
package pipeline_stall_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LW_STALL = 2'd1,
        ST_MD_BUSY  = 2'd2,
        ST_UNUSED   = 2'd3
    } ctrl_state_t;

    localparam int unsigned MD_LATENCY_DEFAULT = 4;
    localparam int unsigned MD_CNT_W           = 4;

endpackage

// File: rtl/pipeline_stall_controller_md_counter.sv
// Mult/div latency down-counter: load, decrement and an is_one flag for the final busy cycle.
module md_latency_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         is_one
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign is_one = (count == W'(1));

endmodule

// File: rtl/pipeline_stall_controller.sv
// Hazard/stall controller: Mealy FSM for load-use stalls, branch flushes and mult/div busy periods.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lw_hazard,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             md_start,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             md_done,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_count
);

    ctrl_state_t          state_q, state_d;
    logic                 cnt_load, cnt_dec, cnt_is_one;
    logic [MD_CNT_W-1:0]  cnt_value;

    md_latency_counter #(.W(MD_CNT_W)) u_md_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (MD_CNT_W'(MD_LATENCY - 1)),
        .dec        (cnt_dec),
        .count      (cnt_value),
        .is_one     (cnt_is_one)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = ST_RUN;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        md_done     = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;

        unique case (state_q)
            ST_RUN, ST_LW_STALL: begin
                // LW_STALL behaves as RUN except that the repeated lw_hazard is ignored
                if (md_start) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    cnt_load    = 1'b1;
                    state_d     = ST_MD_BUSY;
                end else if (lw_hazard && state_q == ST_RUN) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    state_d     = ST_LW_STALL;
                end else if (branch_taken || jump) begin
                    ifid_flush  = 1'b1;
                end
            end
            ST_MD_BUSY: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                cnt_dec     = 1'b1;
                if (cnt_is_one) begin
                    md_done = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_MD_BUSY;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            md_done     = 1'b0;
        end
    end

    assign ctrl_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (!pc_write && stall_count != '1) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: directed scenarios plus randomized traffic against a behavioural model.
module tb_pipeline_stall_controller;

    localparam int unsigned LAT = 4;
    localparam int unsigned CW  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lw_hazard = 1'b0, branch_taken = 1'b0, jump = 1'b0, md_start = 1'b0;
    logic          pc_write, ifid_write, ifid_flush, idex_bubble, md_done;
    logic [1:0]    ctrl_state;
    logic [CW-1:0] stall_count;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    pipeline_stall_controller #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .lw_hazard    (lw_hazard),
        .branch_taken (branch_taken),
        .jump         (jump),
        .md_start     (md_start),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .md_done      (md_done),
        .ctrl_state   (ctrl_state),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: busy_left = remaining busy cycles after the start cycle,
    // lw_pending = previous cycle was a load-use stall.
    int unsigned   busy_left = 0;
    bit            lw_pending = 0;
    bit            mvalid = 0;
    int unsigned   mcount = 0;

    always @(negedge clk) begin
        bit e_stall, e_flush, e_done;
        int unsigned e_state;
        e_stall = 0; e_flush = 0; e_done = 0;
        e_state = (busy_left > 0) ? 2 : (lw_pending ? 1 : 0);
        if (rst) begin
            chk("rst_pc_write", pc_write, 0);
            chk("rst_ifid_write", ifid_write, 0);
            chk("rst_ifid_flush", ifid_flush, 1);
            chk("rst_idex_bubble", idex_bubble, 1);
            chk("rst_md_done", md_done, 0);
            if (mvalid) begin
                chk("rst_ctrl_state", ctrl_state, e_state);
                chk("rst_stall_count", stall_count, mcount);
            end
            busy_left = 0; lw_pending = 0; mcount = 0; mvalid = 1;
        end else if (mvalid) begin
            if (busy_left > 0) begin
                e_stall = 1;
                e_done  = (busy_left == 1);
            end else if (md_start) begin
                e_stall = 1;
            end else if (lw_hazard && !lw_pending) begin
                e_stall = 1;
            end else begin
                e_flush = branch_taken | jump;
            end
            chk("pc_write", pc_write, !e_stall);
            chk("ifid_write", ifid_write, !e_stall);
            chk("idex_bubble", idex_bubble, e_stall);
            chk("ifid_flush", ifid_flush, e_flush);
            chk("md_done", md_done, e_done);
            chk("ctrl_state", ctrl_state, e_state);
            chk("stall_count", stall_count, mcount);
            if (busy_left > 0) begin
                busy_left--;
                lw_pending = 0;
            end else if (md_start) begin
                busy_left  = LAT - 1;
                lw_pending = 0;
            end else begin
                lw_pending = lw_hazard && !lw_pending;
            end
            if (e_stall && mcount < (1 << CW) - 1) mcount++;
        end
    end

    task automatic drive(input bit r, input bit l, input bit b, input bit j, input bit m);
        @(posedge clk); #1;
        rst = r; lw_hazard = l; branch_taken = b; jump = j; md_start = m;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
    endtask

    initial begin
        int unsigned done_seen;

        // Reset then idle
        do_reset();
        repeat (3) drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("idle_pc_write", pc_write, 1);
        chk("idle_ifid_write", ifid_write, 1);
        chk("idle_state", ctrl_state, 0);
        chk("idle_count", stall_count, 0);

        // Load-use held two cycles gives one stall
        drive(0, 1, 0, 0, 0);
        @(negedge clk);
        chk("lw_stall_pc", pc_write, 0);
        chk("lw_stall_bubble", idex_bubble, 1);
        drive(0, 1, 0, 0, 0);
        @(negedge clk);
        chk("lw_after_pc", pc_write, 1);
        chk("lw_after_state", ctrl_state, 1);
        chk("lw_after_count", stall_count, 1);

        // Load-use beats branch, branch honoured next cycle
        drive(0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0);
        @(negedge clk);
        chk("lwbr_flush", ifid_flush, 0);
        chk("lwbr_pc", pc_write, 0);
        drive(0, 0, 1, 0, 0);
        @(negedge clk);
        chk("br_flush", ifid_flush, 1);
        chk("br_pc", pc_write, 1);

        // Mult/div: four stall cycles, md_done on the fourth only
        do_reset();
        drive(0, 0, 0, 0, 1);
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("md_pc_write", pc_write, 0);
            chk("md_done_pos", md_done, (i == 3) ? 1 : 0);
            done_seen += md_done;
            drive(0, 1, 1, 1, 0);
        end
        @(negedge clk);
        chk("md_done_once", done_seen, 1);
        chk("md_end_state", ctrl_state, 0);
        chk("md_end_count", stall_count, 4);

        // Reset in the second busy cycle aborts without md_done
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("abort_done", md_done, 0);
        chk("abort_flush", ifid_flush, 1);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("abort_state", ctrl_state, 0);
        chk("abort_done2", md_done, 0);
        chk("abort_pc", pc_write, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 10);
        end

        // Saturation: continuous stalling past 2^16-1
        do_reset();
        for (int i = 0; i < 65540; i++) drive(0, 0, 0, 0, 1);
        @(negedge clk);
        chk("sat_count", stall_count, 16'hFFFF);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sat_hold", stall_count, 16'hFFFF);

        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have parameter MD_LATENCY, default 4, mult/div execute cycles; legal range 2..15.
REQ-002 SHALL have parameter CNT_W, default 16, width of the stall statistics counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset, sampled on the clk rising edge.
REQ-005 SHALL have port lw_hazard, input, 1, load-use hazard detected for the instruction in ID.
REQ-006 SHALL have port branch_taken, input, 1, branch in ID resolved taken.
REQ-007 SHALL have port jump, input, 1, jump instruction decoded in ID.
REQ-008 SHALL have port md_start, input, 1, mult/div instruction entering EX this cycle.
REQ-009 SHALL have port pc_write, output, 1, PC load enable.
REQ-010 SHALL have port ifid_write, output, 1, IF/ID register load enable.
REQ-011 SHALL have port ifid_flush, output, 1, clear IF/ID to NOP on the next edge.
REQ-012 SHALL have port idex_bubble, output, 1, select zeroed control word into ID/EX.
REQ-013 SHALL have port md_done, output, 1, one-cycle pulse when a mult/div result is ready.
REQ-014 SHALL have port ctrl_state, output, 2, current FSM state encoding.
REQ-015 SHALL have port stall_count, output, CNT_W, saturating count of cycles with pc_write=0 outside reset.

Function
REQ-016 SHALL implement states RUN=2'd0, LW_STALL=2'd1, MD_BUSY=2'd2; encoding 2'd3 is unused and SHALL return to RUN on the next edge with RUN outputs.
REQ-017 SHALL drive outputs combinationally from the current state and inputs (Mealy), with zero latency from a hazard input to the stall or flush output.
REQ-018 In RUN with no inputs active: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
REQ-019 Priority in RUN SHALL be md_start > lw_hazard > (branch_taken | jump).
REQ-020 In RUN with md_start=1: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0; counter loads MD_LATENCY-1; next state MD_BUSY.
REQ-021 In RUN with lw_hazard=1 and md_start=0: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0; next state LW_STALL; branch_taken and jump are ignored that cycle.
REQ-022 In RUN with branch_taken or jump=1 only: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=0; state remains RUN.
REQ-023 LW_STALL SHALL last exactly one cycle with RUN outputs per REQ-018/REQ-022, and lw_hazard SHALL be ignored; md_start and branch/jump SHALL be honoured as in RUN; next state is RUN unless md_start=1.
REQ-024 In MD_BUSY: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0; all inputs are ignored; the counter decrements by 1 each cycle.
REQ-025 When the counter is 1 in MD_BUSY, md_done SHALL be 1 that cycle and the next state SHALL be RUN; md_start back-to-back in RUN re-enters MD_BUSY.
REQ-026 Total pc_write=0 cycles per mult/div SHALL equal MD_LATENCY, counting the md_start cycle.
REQ-027 stall_count SHALL increment on every edge where pc_write=0 and rst=0, and SHALL hold at 2^CNT_W-1.

Reset
REQ-028 With rst=1 at an edge: state goes to RUN, counter goes to 0, and stall_count goes to 0.
REQ-029 While rst=1, outputs SHALL be pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, md_done=0, irrespective of state.
REQ-030 A reset during MD_BUSY SHALL abort the operation with no md_done pulse, and RUN resumes on the first cycle after rst deasserts.

Structure
REQ-031 State encodings and the MD_LATENCY default SHALL reside in the shared pipeline definitions include file.
REQ-032 The down-counter SHALL be a sub-module md_latency_counter (load, decrement, is_one flag); the FSM, output decode and statistics SHALL stay in the top module.

Verification
REQ-033 Reset, then idle for 3 cycles -> pc_write=1, ifid_write=1, ctrl_state=0, stall_count=0.
REQ-034 lw_hazard=1 held for 2 cycles -> exactly 1 stall cycle (pc_write=0, idex_bubble=1), then LW_STALL with pc_write=1; stall_count=1.
REQ-035 lw_hazard=1 and branch_taken=1 in the same cycle -> stall cycle with ifid_flush=0; branch_taken=1 in the next cycle -> ifid_flush=1 and pc_write=1.
REQ-036 md_start=1 with MD_LATENCY=4 -> pc_write=0 for 4 cycles, md_done=1 in the 4th cycle only, then RUN; stall_count=4.
REQ-037 md_start, then rst=1 in the 2nd MD_BUSY cycle -> md_done never asserts, outputs follow REQ-029, and ctrl_state=0 after release.
REQ-038 Force stall_count to 16'hFFFE, then apply 3 stall cycles -> stall_count=16'hFFFF and remains there.
